mc_controller: RTL and testbench

- Multi-cycle MIPS main controller: a Moore FSM that sequences each instruction over 3–5 cycles.
- Drives the datapath muxes, the memory/register strobes and the 3-bit ALU ctrl code. It is the producer end of the ALU ctrl/zero interface.
- Consumes the ALU zero flag for beq resolution.
- Sits between the instruction register (opcode/funct fields) and the shared-memory multi-cycle datapath.

---
 rtl/mc_controller.sv | 191 +++++++++++++++++++
 tb/tb_mc_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch, decode and
// per-class execute/memory/writeback states; only pc_en also depends on zero.
module mc_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_ctrl,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_LWWB  = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BEQ   = 4'd8,
    S_IEX   = 4'd9,
    S_IWB   = 4'd10,
    S_JMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state;
  logic [3:0]         nx;

  logic       pc_write_c, pc_write_cond_c;
  logic       i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_src_c;
  logic [2:0] alu_ctrl_c;

  logic [2:0] r_ctrl;
  logic       r_known;

  // R-type decode is shared by REX and RWB; funct is stable until the next IR load
  always_comb begin
    r_known = 1'b1;
    r_ctrl  = ALU_ADD;
    unique case (funct)
      6'b100000: r_ctrl = ALU_ADD;
      6'b100010: r_ctrl = ALU_SUB;
      6'b100100: r_ctrl = ALU_AND;
      6'b100101: r_ctrl = ALU_OR;
      6'b101010: r_ctrl = ALU_SLT;
      default: begin
        r_ctrl  = ALU_ADD;
        r_known = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= '0;
    else     state <= STATE_W'(nx);
  end

  always_comb begin
    nx              = S_IF;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    pc_src_c        = 2'b00;
    alu_ctrl_c      = 3'b000;
    case (state[3:0])
      S_IF: begin
        mem_read_c  = 1'b1;
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'b01;
        alu_ctrl_c  = ALU_ADD;
        pc_write_c  = 1'b1;
        nx          = S_ID;
      end
      S_ID: begin
        alu_src_b_c = 2'b11;
        alu_ctrl_c  = ALU_ADD;
        case (opcode)
          OP_RTYPE:     nx = S_REX;
          OP_LW, OP_SW: nx = S_MADDR;
          OP_BEQ:       nx = S_BEQ;
          OP_ADDI:      nx = S_IEX;
          OP_J:         nx = S_JMP;
          default:      nx = S_IF;
        endcase
      end
      S_MADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_ctrl_c  = ALU_ADD;
        if (opcode == OP_LW)      nx = S_MRD;
        else if (opcode == OP_SW) nx = S_MWR;
        else                      nx = S_IF;
      end
      S_MRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        nx         = S_LWWB;
      end
      S_LWWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      S_MWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
      end
      S_REX: begin
        alu_src_a_c = 1'b1;
        alu_ctrl_c  = r_ctrl;
        nx          = r_known ? S_RWB : S_IF;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        alu_ctrl_c  = r_ctrl;
      end
      S_BEQ: begin
        alu_src_a_c     = 1'b1;
        alu_ctrl_c      = ALU_SUB;
        pc_src_c        = 2'b01;
        pc_write_cond_c = 1'b1;
      end
      S_IEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_ctrl_c  = ALU_ADD;
        nx          = S_IWB;
      end
      S_IWB: reg_write_c = 1'b1;
      S_JMP: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
      end
      default: nx = S_IF;
    endcase
  end

  // Reset masks every strobe combinationally so an abandoned instruction writes nothing
  assign pc_en      = ~rst & (pc_write_c | (pc_write_cond_c & zero));
  assign i_or_d     = ~rst & i_or_d_c;
  assign mem_read   = ~rst & mem_read_c;
  assign mem_write  = ~rst & mem_write_c;
  assign ir_write   = ~rst & ir_write_c;
  assign reg_dst    = ~rst & reg_dst_c;
  assign mem_to_reg = ~rst & mem_to_reg_c;
  assign reg_write  = ~rst & reg_write_c;
  assign alu_src_a  = ~rst & alu_src_a_c;
  assign alu_src_b  = rst ? '0 : alu_src_b_c;
  assign pc_src     = rst ? '0 : pc_src_c;
  assign alu_ctrl   = rst ? '0 : alu_ctrl_c;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle expectations are
// queued by the driver and popped/compared by a negedge monitor.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] dbg_state;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] o;
  } rec_t;

  rec_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rw_cnt   = 0;

  logic [15:0] act;
  assign act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl};

  // Phase numbers: 0 IF,1 ID,2 MADDR,3 MRD,4 LWWB,5 MWR,6 REX,7 RWB,8 BEQ,9 IEX,10 IWB,11 JMP
  function automatic logic [15:0] exp_out(input int ph, input logic [2:0] rop, input logic z);
    logic pe = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ac = 0;
    case (ph)
      0:  begin mr = 1; irw = 1; sb = 2'b01; ac = 3'b010; pe = 1; end
      1:  begin sb = 2'b11; ac = 3'b010; end
      2:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; ac = rop; end
      7:  begin rw = 1; rd = 1; ac = rop; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ps, ac};
  endfunction

  function automatic logic [3:0] r_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b1_010;
      6'h22:   return 4'b1_110;
      6'h24:   return 4'b1_000;
      6'h25:   return 4'b1_001;
      6'h2A:   return 4'b1_111;
      default: return 4'b0_010;
    endcase
  endfunction

  // Push the full expected cycle sequence of one instruction.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int upto);
    int ph[$];
    logic [3:0] r = r_op(fn);
    case (op)
      6'h23:   ph = '{0, 1, 2, 3, 4};
      6'h2B:   ph = '{0, 1, 2, 5};
      6'h00:   ph = r[3] ? '{0, 1, 6, 7} : '{0, 1, 6};
      6'h04:   ph = '{0, 1, 8};
      6'h08:   ph = '{0, 1, 9, 10};
      6'h02:   ph = '{0, 1, 11};
      default: ph = '{0, 1};
    endcase
    for (int i = 0; i < ph.size() && i < upto; i++)
      q.push_back('{st: 4'(ph[i]), o: exp_out(ph[i], r[2:0], z)});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s timeout: queue=%0d required=0", name, q.size());
      q.delete();
    end
  endtask

  // Called at posedge+1 with the DUT in IF; returns at posedge+1 of the next IF.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input bit toggle);
    opcode = op; funct = fn; zero = z;
    push_instr(op, fn, z, 99);
    if (toggle) begin
      @(posedge clk); @(posedge clk); #1;
      zero = ~z; #1;
      checks++;
      if (pc_en !== ~z) begin failures++; $display("FAIL beq_toggle pc_en=%b required=%b", pc_en, ~z); end
      zero = z; #1;
      checks++;
      if (pc_en !== z) begin failures++; $display("FAIL beq_restore pc_en=%b required=%b", pc_en, z); end
    end
    wait_drain("instr");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (mem_read & mem_write) begin
      checks++; failures++;
      $display("FAIL mem_rw_excl mem_read=%b mem_write=%b required not both", mem_read, mem_write);
    end
    if (ir_write) begin
      checks++;
      if (dbg_state !== 4'd0) begin failures++; $display("FAIL ir_write_state state=%0d required=0", dbg_state); end
    end
    if (dbg_state == 4'd0) rw_cnt = 0;
    if (reg_write) begin
      rw_cnt++;
      checks++;
      if (rw_cnt > 1) begin failures++; $display("FAIL reg_write_once count=%0d required<=1", rw_cnt); end
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({dbg_state, act} !== e) begin
        failures++;
        $display("FAIL cycle state/outs actual=%0d/%h required=%0d/%h", dbg_state, act, e.st, e.o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] kf[5];
    logic [5:0] op, fn;
    kf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rst = 1'b1; opcode = 6'b100011; funct = 6'h20; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({dbg_state, act} !== 20'h0) begin
        failures++;
        $display("FAIL reset state/outs actual=%0d/%h required=0/0000", dbg_state, act);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'h23, 6'h11, 1'b0, 0);
    run_instr(6'h2B, 6'h00, 1'b1, 0);
    for (int i = 0; i < 5; i++) run_instr(6'h00, kf[i], i[0], 0);
    run_instr(6'h00, 6'h3F, 1'b0, 0);
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0);
    run_instr(6'h04, 6'h00, 1'b1, 1);
    run_instr(6'h08, 6'h20, 1'b1, 0);
    run_instr(6'h02, 6'h20, 1'b0, 0);
    run_instr(6'h3F, 6'h20, 1'b1, 0);

    // Reset during MRD: aborted lw must show zeroed outputs and restart at IF
    opcode = 6'h23; funct = 6'h20; zero = 1'b0;
    push_instr(6'h23, 6'h20, 1'b0, 3);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    q.push_back('{st: 4'd3, o: 16'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(6'h00, 6'h2A, 1'b0, 0);

    // Illegal state code must fall back to IF
    force dut.state = 4'd13;
    #1;
    release dut.state;
    q.push_back('{st: 4'd13, o: 16'h0});
    wait_drain("illegal");
    @(posedge clk); #1;
    run_instr(6'h23, 6'h00, 1'b1, 0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: op = 6'h00;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        default: op = 6'($urandom());
      endcase
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom());
      else fn = kf[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom()), (op == 6'h04) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
